t_state_sequencer: RTL and testbench
====================================

Name: t_state_sequencer

Overview:
- Generates the one-hot T-state timing ring (t0..t5) that drives the CPU control unit.
- Shortens each instruction cycle according to the decoded opcode.
- Stops the machine on HALT and supports free-run and single-instruction step modes.
- Sits between the front-panel run/step inputs, the instruction register high nibble and the control unit T inputs.

Parameters:
- COUNT_W, 8, width of retired-instruction counter
- HALT_OP, 4'b1111, opcode that stops the sequencer
- LONG_OP0, 4'b0000, opcode using full t0..t5 cycle (MOV)
- LONG_OP1, 4'b0011, opcode using full t0..t5 cycle (ADD)
- LONG_OP2, 4'b0100, opcode using full t0..t5 cycle (SUB)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = free-run, 0 = step mode
- step  input  1  single-cycle pulse; starts one instruction in step mode
- opcode  input  4  instruction register high nibble
- t0..t5  output  1 each  one-hot T-state outputs, registered
- halted  output  1  machine stopped by HALT
- busy  output  1  any T-state active
- instr_done  output  1  one-cycle pulse on the last T-state of each instruction
- instr_count  output  COUNT_W  retired-instruction count

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALTED. The T outputs are decoded from registered state, so at most one of t0..t5 is 1.
- Reset (asynchronous, any state, including mid-instruction):
  - state = IDLE; t0..t5 = 0; halted = 0; busy = 0; instr_done = 0; instr_count = 0.
- IDLE:
  - Goes to T0 when run=1, or when step=1.
  - Otherwise stays in IDLE.
  - Latency from run/step high to t0 high: 1 clock.
- Ring order: T0 -> T1 -> T2 -> T3, one state per clock, unconditionally.
- T3 decision, using opcode sampled in T3 (the IR is loaded at the end of T1):
  - opcode == HALT_OP: instr_done = 1 this cycle; next state is HALTED.
  - opcode is one of the LONG_OPx: next state is T4. Then T4 -> T5; instr_done = 1 during T5.
  - Any other opcode (including OUT 4'b1110 and undefined opcodes) is a short instruction: instr_done = 1 during T3.
- End of instruction (the cycle with instr_done = 1, not HALT):
  - If run = 1, next state is T0, back-to-back with no idle cycle.
  - Else next state is IDLE.
- Step handling:
  - step is ignored while busy = 1; steps are not queued.
  - Each accepted step executes exactly one instruction.
- Mode changes: run falling mid-instruction does not abort it. The instruction completes, then the sequencer goes to IDLE.
- HALTED:
  - t0..t5 = 0; halted = 1; busy = 0.
  - run and step are ignored (see Optional Feature).
  - Exit by reset only.
- instr_count:
  - Increments by 1 in the cycle after each instr_done, including HALT.
  - Wraps from 2^COUNT_W-1 to 0.
- opcode changes outside T3 have no effect.
- busy = t0|t1|t2|t3|t4|t5.

Optional Feature:
- Macro: SEQ_RESUME_EN.
- Defined:
  - A step pulse while HALTED clears halted and moves to IDLE on the next clock. instr_count is kept.
  - The following run/step behaves as from IDLE.
  - A step coincident with reset is overridden by reset.
- Not defined: HALTED is terminal until reset; step has no effect.

Test Plan:
- Reset mid-T2 with run=1 -> all T outputs 0 and instr_count=0 asynchronously, before the next clk edge. After release, t0 rises 1 clk later.
- run=1, opcode=4'b0011 constant -> t0..t5 repeat with a period of 6 clks. instr_done high in every T5. instr_count=3 after 18 clks.
- run=1, opcode=4'b1110 -> 4-clk period t0..t3. instr_done in T3. t4/t5 never asserted.
- run=0, single step pulse, opcode=4'b0000 -> exactly one t0..t5 sequence, then IDLE. A second step asserted during T2 is ignored. instr_count=1.
- run=1, opcode=4'b1111 -> t0..t3, then halted=1 and busy=0 indefinitely. A step pulse leaves it halted (macro off) or returns to IDLE, where run=1 restarts at t0 (SEQ_RESUME_EN on).
- COUNT_W=2, run=1, opcode=4'b1110 for 5 instructions -> instr_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/t_state_sequencer.sv
// t_state_sequencer
//
// Generates the one-hot T-state timing ring (t0..t5) for the CPU control
// unit. Short instructions end in T3 and long ones (MOV/ADD/SUB) end in T5.
// HALT stops the machine. In free-run mode instructions follow each other
// back to back. In step mode each accepted step pulse runs one instruction.
//
// Build option:
//   SEQ_RESUME_EN - when defined, a step pulse while HALTED returns to IDLE
//                   and keeps the retired count. When undefined, HALTED is
//                   terminal until reset.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous, active-high reset
//   run_i          1 = free-run, 0 = step mode (level)
//   step_i         single-cycle pulse, starts one instruction in step mode
//   opcode_i       instruction register high nibble, sampled in T3
//   t0_o..t5_o     one-hot T-state outputs, registered
//   halted_o       machine stopped by HALT, registered
//   busy_o         any T-state active, registered
//   instr_done_o   high during the last T-state of each instruction
//   instr_count_o  retired-instruction count, wraps
//
// state  | meaning
// IDLE   | waiting for run or step
// T0..T2 | fetch/decode ring, unconditional advance
// T3     | opcode decision: halt, end short instruction, or continue
// T4,T5  | extra execute cycles for long instructions
// HALTED | stopped by HALT

module t_state_sequencer #(
    parameter int         COUNT_W  = 8,
    parameter logic [3:0] HALT_OP  = 4'b1111,
    parameter logic [3:0] LONG_OP0 = 4'b0000,
    parameter logic [3:0] LONG_OP1 = 4'b0011,
    parameter logic [3:0] LONG_OP2 = 4'b0100
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               run_i,
    input  logic               step_i,
    input  logic [3:0]         opcode_i,
    output logic               t0_o,
    output logic               t1_o,
    output logic               t2_o,
    output logic               t3_o,
    output logic               t4_o,
    output logic               t5_o,
    output logic               halted_o,
    output logic               busy_o,
    output logic               instr_done_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           t_q, t_d;
    logic                 halted_q;
    logic                 busy_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 is_long;
    logic                 done;

    assign is_long = (opcode_i == LONG_OP0) || (opcode_i == LONG_OP1) ||
                     (opcode_i == LONG_OP2);

    // instr_done is combinational on purpose. A short instruction ends in
    // the same T3 cycle in which its opcode is sampled, so a registered
    // version would have to sample the opcode one cycle early.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE:   if (run_i || step_i) state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = S_T2;
            S_T2:     state_d = S_T3;
            S_T3: begin
                if (opcode_i == HALT_OP) begin
                    done    = 1'b1;
                    state_d = S_HALTED;
                end else if (is_long) begin
                    state_d = S_T4;
                end else begin
                    done    = 1'b1;
                    state_d = run_i ? S_T0 : S_IDLE;
                end
            end
            S_T4:     state_d = S_T5;
            S_T5: begin
                done    = 1'b1;
                state_d = run_i ? S_T0 : S_IDLE;
            end
            S_HALTED: begin
`ifdef SEQ_RESUME_EN
                if (step_i) state_d = S_IDLE;
`else
                state_d = S_HALTED;
`endif
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with
    // state_q without a decode stage after the flops.
    always_comb begin
        t_d = 6'b000000;
        case (state_d)
            S_T0:    t_d = 6'b000001;
            S_T1:    t_d = 6'b000010;
            S_T2:    t_d = 6'b000100;
            S_T3:    t_d = 6'b001000;
            S_T4:    t_d = 6'b010000;
            S_T5:    t_d = 6'b100000;
            default: t_d = 6'b000000;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            t_q      <= 6'b000000;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            halted_q <= (state_d == S_HALTED);
            busy_q   <= |t_d;
            if (done) count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign t0_o          = t_q[0];
    assign t1_o          = t_q[1];
    assign t2_o          = t_q[2];
    assign t3_o          = t_q[3];
    assign t4_o          = t_q[4];
    assign t5_o          = t_q[5];
    assign halted_o      = halted_q;
    assign busy_o        = busy_q;
    assign instr_done_o  = done;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_t_state_sequencer.sv
module tb_t_state_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [3:0] opcode;

    logic       t0, t1, t2, t3, t4, t5, halted, busy, instr_done;
    logic [7:0] instr_count;
    logic       w_t0, w_t1, w_t2, w_t3, w_t4, w_t5, w_halted, w_busy, w_done;
    logic [1:0] w_count;

    wire [5:0] tv   = {t5, t4, t3, t2, t1, t0};
    wire [5:0] w_tv = {w_t5, w_t4, w_t3, w_t2, w_t1, w_t0};

    always #5 clk = ~clk;

    t_state_sequencer #(.COUNT_W(8)) dut (
        .clk_i(clk), .reset_i(reset), .run_i(run), .step_i(step), .opcode_i(opcode),
        .t0_o(t0), .t1_o(t1), .t2_o(t2), .t3_o(t3), .t4_o(t4), .t5_o(t5),
        .halted_o(halted), .busy_o(busy), .instr_done_o(instr_done),
        .instr_count_o(instr_count)
    );

    t_state_sequencer #(.COUNT_W(2)) dut_w (
        .clk_i(clk), .reset_i(reset), .run_i(run), .step_i(step), .opcode_i(opcode),
        .t0_o(w_t0), .t1_o(w_t1), .t2_o(w_t2), .t3_o(w_t3), .t4_o(w_t4), .t5_o(w_t5),
        .halted_o(w_halted), .busy_o(w_busy), .instr_done_o(w_done),
        .instr_count_o(w_count)
    );

    typedef struct {
        logic       run;
        logic       step;
        logic [3:0] op;
        logic [5:0] t;
        logic       done;
        logic       halt;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic s, input logic [3:0] o,
                       input logic [5:0] t, input logic d, input logic h,
                       input logic [7:0] c);
        vec_t v;
        v.run = r; v.step = s; v.op = o; v.t = t; v.done = d; v.halt = h; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // run, step, op, {t5..t0}, done, halted, count
        add(1, 0, 4'h3, 6'b000000, 0, 0, 0);  // c0  IDLE
        add(1, 0, 4'h3, 6'b000001, 0, 0, 0);  // c1  T0
        add(1, 0, 4'hF, 6'b000010, 0, 0, 0);  // c2  T1, opcode noise outside T3
        add(1, 0, 4'h3, 6'b000100, 0, 0, 0);  // c3  T2
        add(1, 0, 4'h3, 6'b001000, 0, 0, 0);  // c4  T3 long
        add(1, 0, 4'hE, 6'b010000, 0, 0, 0);  // c5  T4, opcode change ignored
        add(1, 0, 4'hE, 6'b100000, 1, 0, 0);  // c6  T5 done
        add(1, 0, 4'hE, 6'b000001, 0, 0, 1);  // c7  back-to-back T0
        add(1, 0, 4'hE, 6'b000010, 0, 0, 1);
        add(1, 0, 4'hE, 6'b000100, 0, 0, 1);
        add(1, 0, 4'hE, 6'b001000, 1, 0, 1);  // c10 T3 short done
        add(0, 0, 4'hE, 6'b000001, 0, 0, 2);  // c11 run drops mid-instruction
        add(0, 0, 4'hE, 6'b000010, 0, 0, 2);
        add(0, 0, 4'hE, 6'b000100, 0, 0, 2);
        add(0, 0, 4'hE, 6'b001000, 1, 0, 2);  // c14 completes
        add(0, 0, 4'hE, 6'b000000, 0, 0, 3);  // c15 IDLE
        add(0, 1, 4'h0, 6'b000000, 0, 0, 3);  // c16 step pulse
        add(0, 0, 4'h0, 6'b000001, 0, 0, 3);
        add(0, 0, 4'h0, 6'b000010, 0, 0, 3);
        add(0, 1, 4'h0, 6'b000100, 0, 0, 3);  // c19 step during T2 ignored
        add(0, 0, 4'h0, 6'b001000, 0, 0, 3);
        add(0, 0, 4'h0, 6'b010000, 0, 0, 3);
        add(0, 0, 4'h0, 6'b100000, 1, 0, 3);  // c22 T5 done
        add(0, 0, 4'h0, 6'b000000, 0, 0, 4);  // c23 IDLE, step not queued
        add(1, 0, 4'hF, 6'b000000, 0, 0, 4);  // c24 run with HALT
        add(1, 0, 4'hF, 6'b000001, 0, 0, 4);
        add(1, 0, 4'hF, 6'b000010, 0, 0, 4);
        add(1, 0, 4'hF, 6'b000100, 0, 0, 4);
        add(1, 0, 4'hF, 6'b001000, 1, 0, 4);  // c28 HALT done in T3
        add(1, 0, 4'hF, 6'b000000, 0, 1, 5);  // c29 HALTED
        add(1, 0, 4'hF, 6'b000000, 0, 1, 5);

        reset = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset t", {26'd0, tv}, 32'd0);
        chk("reset flags", {29'd0, halted, busy, instr_done}, 32'd0);
        chk("reset count", {24'd0, instr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            run = vecs[i].run; step = vecs[i].step; opcode = vecs[i].op;
            #1;
            chk($sformatf("v%0d t", i), {26'd0, tv}, {26'd0, vecs[i].t});
            chk($sformatf("v%0d done", i), {31'd0, instr_done}, {31'd0, vecs[i].done});
            chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].halt});
            chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, |vecs[i].t});
            chk($sformatf("v%0d count", i), {24'd0, instr_count}, {24'd0, vecs[i].cnt});
            chk($sformatf("v%0d w2 count", i), {30'd0, w_count}, {30'd0, vecs[i].cnt[1:0]});
            chk($sformatf("v%0d w2 outs", i), {23'd0, w_tv, w_halted, w_busy, w_done},
                {23'd0, vecs[i].t, vecs[i].halt, |vecs[i].t, vecs[i].done});
        end

        // Step pulse while HALTED (run still 1, opcode still HALT).
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        #1;
`ifdef SEQ_RESUME_EN
        chk("resume halted", {31'd0, halted}, 32'd0);
        chk("resume busy", {31'd0, busy}, 32'd0);
        chk("resume count", {24'd0, instr_count}, 32'd5);
        tick();
        chk("resume restart t", {26'd0, tv}, 32'b000001);
`else
        chk("halt step halted", {31'd0, halted}, 32'd1);
        chk("halt step busy", {31'd0, busy}, 32'd0);
        chk("halt step count", {24'd0, instr_count}, 32'd5);
        tick();
        chk("halt hold t", {26'd0, tv}, 32'd0);
        chk("halt hold halted", {31'd0, halted}, 32'd1);
`endif

        // Asynchronous reset, then restart and reset again mid-T2.
        reset = 1'b1;
        #1;
        chk("async reset halted", {31'd0, halted}, 32'd0);
        chk("async reset count", {24'd0, instr_count}, 32'd0);
        run = 1'b1; opcode = 4'hE;
        #1;
        reset = 1'b0;
        tick();
        chk("restart t0", {26'd0, tv}, 32'b000001);
        tick(); tick(); tick();
        chk("restart T3", {26'd0, tv}, 32'b001000);
        tick(); tick(); tick();
        chk("pre-reset T2", {26'd0, tv}, 32'b000100);
        chk("pre-reset count", {24'd0, instr_count}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid T2 reset t", {26'd0, tv}, 32'd0);
        chk("mid T2 reset count", {24'd0, instr_count}, 32'd0);
        chk("mid T2 reset busy", {31'd0, busy}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("post reset t0", {26'd0, tv}, 32'b000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
